// File: rtl/cpu_pkg.sv
// Shared CPU constants and the interrupt-controller state encoding.
// Used by the interrupt controller, its pending/priority sub-block and the bench.
package cpu_pkg;

  localparam int N_IRQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int SEL_W  = 2;
  localparam logic [ADDR_W-1:0] VEC_BASE = 10'h3F0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_VECTOR = 2'd2
  } ic_state_t;

endpackage

// File: rtl/irq_pend.sv
// Interrupt edge detector, pending latch, mask register and fixed-priority select.
// Line 0 has the highest priority; masked lines still latch pending.
module irq_pend
  import cpu_pkg::*;
#(
  parameter int P_N_IRQ = N_IRQ,
  parameter int P_SEL_W = SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [P_N_IRQ-1:0] i_irq,
  input  logic               i_mask_we,
  input  logic [P_N_IRQ-1:0] i_mask_in,
  input  logic [P_N_IRQ-1:0] i_ack,
  output logic               o_any_req,
  output logic [P_SEL_W-1:0] o_sel_idx
);

  logic [P_N_IRQ-1:0] r_irq_q;
  logic [P_N_IRQ-1:0] r_pend;
  logic [P_N_IRQ-1:0] r_mask;
  logic [P_N_IRQ-1:0] w_edge;
  logic [P_N_IRQ-1:0] w_eligible;
  logic [P_SEL_W-1:0] w_sel;

  assign w_edge     = i_irq & ~r_irq_q;
  assign w_eligible = r_pend & ~r_mask;

  // A fresh edge in the ack cycle keeps the bit set: the new request wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '1;
    end else begin
      r_irq_q <= i_irq;
      r_pend  <= (r_pend & ~i_ack) | w_edge;
      if (i_mask_we) r_mask <= i_mask_in;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = P_N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel = P_SEL_W'(i);
    end
  end

  assign o_any_req = |w_eligible;
  assign o_sel_idx = w_sel;

endmodule

// File: rtl/ctrl_interrupciones.sv
// Interrupt and return-stack sequencer between the CPU control unit and pila.
// Owns all pila push/pop/s_intr strobes, tracks occupancy and flags over/underflow.
module ctrl_interrupciones
  import cpu_pkg::*;
#(
  parameter int                  P_N_IRQ    = N_IRQ,
  parameter int                  P_ADDR_W   = ADDR_W,
  parameter int                  P_DEPTH    = DEPTH,
  parameter logic [P_ADDR_W-1:0] P_VEC_BASE = VEC_BASE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [P_N_IRQ-1:0]  irq,
  input  logic                mask_we,
  input  logic [P_N_IRQ-1:0]  mask_in,
  input  logic                instr_done,
  input  logic                cpu_call,
  input  logic                cpu_ret,
  input  logic                cpu_reti,
  input  logic [P_ADDR_W-1:0] pc_cur,
  output logic                stk_push,
  output logic                stk_pop,
  output logic                stk_intr,
  output logic [P_ADDR_W-1:0] stk_dato,
  output logic                pc_load,
  output logic [P_ADDR_W-1:0] pc_vec,
  output logic                cpu_stall,
  output logic [P_N_IRQ-1:0]  irq_ack,
  output logic                in_service,
  output logic [CNT_W-1:0]    stk_count,
  output logic                ovf_err,
  output logic                unf_err,
  output ic_state_t           dbg_state
);

  ic_state_t           r_state, w_state_nxt;
  logic [P_ADDR_W-1:0] r_pc_save;
  logic [SEL_W-1:0]    r_irq_sel;
  logic                r_in_service;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf, r_unf;

  logic                w_any_req;
  logic [SEL_W-1:0]    w_sel_idx;
  logic                w_cpu_req, w_take, w_full, w_empty;
  logic                w_push_req, w_pop_req, w_intr, w_pc_load;
  logic [P_ADDR_W-1:0] w_dato;
  logic [P_N_IRQ-1:0]  w_ack;

  irq_pend #(.P_N_IRQ(P_N_IRQ), .P_SEL_W(SEL_W)) u_irq_pend (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (irq),
    .i_mask_we (mask_we),
    .i_mask_in (mask_in),
    .i_ack     (w_ack),
    .o_any_req (w_any_req),
    .o_sel_idx (w_sel_idx)
  );

  // CPU requests are single-cycle strobes, at most one per cycle, honoured
  // only in IDLE; while cpu_stall is high the CPU must not raise them.
  assign w_cpu_req = cpu_call | cpu_ret | cpu_reti;
  assign w_full    = (r_count == CNT_W'(P_DEPTH));
  assign w_empty   = (r_count == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_pop_req   = 1'b0;
    w_intr      = 1'b0;
    w_pc_load   = 1'b0;
    w_take      = 1'b0;
    w_dato      = pc_cur;
    w_ack       = '0;
    case (r_state)
      ST_IDLE: begin
        w_push_req = cpu_call;
        w_pop_req  = cpu_ret | cpu_reti;
        w_intr     = cpu_reti & r_in_service;
        w_take     = instr_done & w_any_req & ~r_in_service & ~w_cpu_req & ~w_full;
        if (w_take) w_state_nxt = ST_ENTRY;
      end
      ST_ENTRY: begin
        w_push_req  = 1'b1;
        w_dato      = r_pc_save;
        w_state_nxt = ST_VECTOR;
      end
      ST_VECTOR: begin
        w_pc_load         = 1'b1;
        w_ack[r_irq_sel]  = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pc_save    <= '0;
      r_irq_sel    <= '0;
      r_in_service <= 1'b0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_pc_save <= pc_cur;
        r_irq_sel <= w_sel_idx;
      end
      if (r_state == ST_VECTOR) r_in_service <= 1'b1;
      else if (w_intr)          r_in_service <= 1'b0;
      if (w_push_req && !w_full)       r_count <= r_count + 1'b1;
      else if (w_pop_req && !w_empty)  r_count <= r_count - 1'b1;
      if (w_push_req && w_full)  r_ovf <= 1'b1;
      if (w_pop_req && w_empty)  r_unf <= 1'b1;
    end
  end

  assign stk_push   = w_push_req & ~w_full;
  assign stk_pop    = w_pop_req & ~w_empty;
  assign stk_intr   = w_intr;
  assign stk_dato   = w_dato;
  assign pc_load    = w_pc_load;
  assign pc_vec     = P_VEC_BASE + P_ADDR_W'(r_irq_sel);
  assign cpu_stall  = w_take | (r_state != ST_IDLE);
  assign irq_ack    = w_ack;
  assign in_service = r_in_service;
  assign stk_count  = r_count;
  assign ovf_err    = r_ovf;
  assign unf_err    = r_unf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ctrl_interrupciones.sv
// Directed bench for ctrl_interrupciones: stack pass-through table plus
// hand-written interrupt entry/exit, masking, overflow and reset sequences.
module tb_ctrl_interrupciones;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_IRQ-1:0]  irq = '0;
  logic              mask_we = 1'b0;
  logic [N_IRQ-1:0]  mask_in = '0;
  logic              instr_done = 1'b0;
  logic              cpu_call = 1'b0, cpu_ret = 1'b0, cpu_reti = 1'b0;
  logic [ADDR_W-1:0] pc_cur = '0;
  logic              stk_push, stk_pop, stk_intr, pc_load, cpu_stall, in_service;
  logic [ADDR_W-1:0] stk_dato, pc_vec;
  logic [N_IRQ-1:0]  irq_ack;
  logic [CNT_W-1:0]  stk_count;
  logic              ovf_err, unf_err;
  ic_state_t         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_interrupciones dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .instr_done(instr_done), .cpu_call(cpu_call), .cpu_ret(cpu_ret),
    .cpu_reti(cpu_reti), .pc_cur(pc_cur), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_intr(stk_intr), .stk_dato(stk_dato), .pc_load(pc_load), .pc_vec(pc_vec),
    .cpu_stall(cpu_stall), .irq_ack(irq_ack), .in_service(in_service),
    .stk_count(stk_count), .ovf_err(ovf_err), .unf_err(unf_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic              call, ret, reti;
    logic [ADDR_W-1:0] pc;
    logic              exp_push, exp_pop, exp_intr;
    logic [ADDR_W-1:0] exp_dato;
    logic [CNT_W-1:0]  exp_count;
    logic              exp_unf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr_in();
    irq = '0; mask_we = 1'b0; mask_in = '0; instr_done = 1'b0;
    cpu_call = 1'b0; cpu_ret = 1'b0; cpu_reti = 1'b0; pc_cur = '0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic write_mask(input logic [N_IRQ-1:0] m);
    mask_we = 1'b1; mask_in = m;
    tick();
    mask_we = 1'b0; mask_in = '0;
  endtask

  task automatic do_reti();
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'h011, 1'b1, 1'b0, 1'b0, 10'h011, 5'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 10'h022, 1'b1, 1'b0, 1'b0, 10'h022, 5'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 10'h033, 1'b0, 1'b1, 1'b0, 10'h033, 5'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 10'h044, 1'b0, 1'b1, 1'b0, 10'h044, 5'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 10'h055, 1'b0, 1'b0, 1'b0, 10'h055, 5'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 10'h066, 1'b0, 1'b0, 1'b0, 10'h066, 5'd0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 10'h077, 1'b1, 1'b0, 1'b0, 10'h077, 5'd0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 10'h088, 1'b0, 1'b1, 1'b0, 10'h088, 5'd1, 1'b1};

    // reset state, checked while reset is held and just after release
    clr_in();
    #1;
    chk("rst_push", 32'(stk_push), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_pc_vec", 32'(pc_vec), 32'h3F0);
    do_reset();
    chk("rst_count", 32'(stk_count), 32'd0);
    chk("rst_flags", 32'({ovf_err, unf_err, in_service, pc_load}), 32'd0);
    chk("rst_ack", 32'(irq_ack), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_dato", 32'(stk_dato), 32'd0);

    // stack pass-through table
    for (int i = 0; i < 8; i++) begin
      cpu_call = tbl[i].call; cpu_ret = tbl[i].ret; cpu_reti = tbl[i].reti;
      pc_cur = tbl[i].pc;
      settle();
      chk($sformatf("tbl%0d_push", i), 32'(stk_push), 32'(tbl[i].exp_push));
      chk($sformatf("tbl%0d_pop", i), 32'(stk_pop), 32'(tbl[i].exp_pop));
      chk($sformatf("tbl%0d_intr", i), 32'(stk_intr), 32'(tbl[i].exp_intr));
      chk($sformatf("tbl%0d_dato", i), 32'(stk_dato), 32'(tbl[i].exp_dato));
      chk($sformatf("tbl%0d_count", i), 32'(stk_count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_unf", i), 32'(unf_err), 32'(tbl[i].exp_unf));
      tick();
    end
    clr_in();
    settle();
    chk("tbl_end_count", 32'(stk_count), 32'd0);

    // single interrupt on line 2
    do_reset();
    write_mask(4'b0000);
    irq = 4'b0100;
    tick();
    irq = '0; instr_done = 1'b1; pc_cur = 10'h040;
    settle();
    chk("t1_take_stall", 32'(cpu_stall), 32'd1);
    chk("t1_take_push", 32'(stk_push), 32'd0);
    tick();
    instr_done = 1'b0; pc_cur = 10'h041;
    settle();
    chk("t1_entry_state", 32'(dbg_state), 32'(ST_ENTRY));
    chk("t1_entry_push", 32'(stk_push), 32'd1);
    chk("t1_entry_dato", 32'(stk_dato), 32'h040);
    chk("t1_entry_stall", 32'(cpu_stall), 32'd1);
    tick();
    settle();
    chk("t1_vec_load", 32'(pc_load), 32'd1);
    chk("t1_vec_pc", 32'(pc_vec), 32'h3F2);
    chk("t1_vec_ack", 32'(irq_ack), 32'b0100);
    chk("t1_vec_count", 32'(stk_count), 32'd1);
    tick();
    settle();
    chk("t1_post_stall", 32'(cpu_stall), 32'd0);
    chk("t1_post_insvc", 32'(in_service), 32'd1);
    chk("t1_post_ack", 32'(irq_ack), 32'd0);
    cpu_reti = 1'b1;
    settle();
    chk("t1_reti_pop", 32'(stk_pop), 32'd1);
    chk("t1_reti_intr", 32'(stk_intr), 32'd1);
    tick();
    cpu_reti = 1'b0;
    settle();
    chk("t1_reti_insvc", 32'(in_service), 32'd0);
    chk("t1_reti_count", 32'(stk_count), 32'd0);

    // simultaneous edges on lines 3 and 1
    irq = 4'b1010;
    tick();
    irq = '0; instr_done = 1'b1; pc_cur = 10'h100;
    settle();
    chk("t2_take1", 32'(cpu_stall), 32'd1);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t2_entry1_dato", 32'(stk_dato), 32'h100);
    tick();
    settle();
    chk("t2_vec1_ack", 32'(irq_ack), 32'b0010);
    chk("t2_vec1_pc", 32'(pc_vec), 32'h3F1);
    tick();
    instr_done = 1'b1;
    settle();
    chk("t2_nested_blocked", 32'(cpu_stall), 32'd0);
    tick();
    instr_done = 1'b0;
    do_reti();
    instr_done = 1'b1; pc_cur = 10'h200;
    settle();
    chk("t2_take3", 32'(cpu_stall), 32'd1);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t2_entry3_dato", 32'(stk_dato), 32'h200);
    tick();
    settle();
    chk("t2_vec3_ack", 32'(irq_ack), 32'b1000);
    chk("t2_vec3_pc", 32'(pc_vec), 32'h3F3);
    tick();
    do_reti();

    // masked line 0 latches pending but is not taken until unmasked
    write_mask(4'b0001);
    irq = 4'b0001;
    tick();
    irq = '0; instr_done = 1'b1; pc_cur = 10'h300;
    settle();
    chk("t3_masked_stall", 32'(cpu_stall), 32'd0);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t3_masked_state", 32'(dbg_state), 32'(ST_IDLE));
    write_mask(4'b0000);
    instr_done = 1'b1;
    settle();
    chk("t3_unmask_take", 32'(cpu_stall), 32'd1);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t3_entry_dato", 32'(stk_dato), 32'h300);
    tick();
    settle();
    chk("t3_vec_ack", 32'(irq_ack), 32'b0001);
    chk("t3_vec_pc", 32'(pc_vec), 32'h3F0);
    tick();
    do_reti();

    // CPU call wins over an eligible take; edge during ack stays pending
    irq = 4'b0100;
    tick();
    irq = '0; instr_done = 1'b1; cpu_call = 1'b1; pc_cur = 10'h055;
    settle();
    chk("t5_call_push", 32'(stk_push), 32'd1);
    chk("t5_call_dato", 32'(stk_dato), 32'h055);
    chk("t5_call_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_call = 1'b0; pc_cur = 10'h056;
    settle();
    chk("t5_still_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t5_retry_take", 32'(cpu_stall), 32'd1);
    chk("t5_count1", 32'(stk_count), 32'd1);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t5_entry_dato", 32'(stk_dato), 32'h056);
    tick();
    irq = 4'b0100;
    settle();
    chk("t5_vec_ack", 32'(irq_ack), 32'b0100);
    tick();
    irq = '0;
    settle();
    chk("t5_count2", 32'(stk_count), 32'd2);
    do_reti();
    instr_done = 1'b1; pc_cur = 10'h057;
    settle();
    chk("t5_repend_take", 32'(cpu_stall), 32'd1);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t5_repend_dato", 32'(stk_dato), 32'h057);
    tick();
    settle();
    chk("t5_repend_ack", 32'(irq_ack), 32'b0100);
    tick();
    do_reti();

    // overflow and underflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cpu_call = 1'b1; pc_cur = ADDR_W'(i + 1);
      settle();
      chk($sformatf("t4_call%0d_push", i), 32'(stk_push), 32'd1);
      tick();
    end
    cpu_call = 1'b0;
    settle();
    chk("t4_full_count", 32'(stk_count), 32'd16);
    chk("t4_full_ovf", 32'(ovf_err), 32'd0);
    cpu_call = 1'b1; pc_cur = 10'h3FF;
    settle();
    chk("t4_ovf_push", 32'(stk_push), 32'd0);
    tick();
    cpu_call = 1'b0;
    settle();
    chk("t4_ovf_flag", 32'(ovf_err), 32'd1);
    chk("t4_ovf_count", 32'(stk_count), 32'd16);
    do_reset();
    cpu_ret = 1'b1;
    settle();
    chk("t4_unf_pop", 32'(stk_pop), 32'd0);
    tick();
    cpu_ret = 1'b0;
    settle();
    chk("t4_unf_flag", 32'(unf_err), 32'd1);
    chk("t4_unf_count", 32'(stk_count), 32'd0);

    // reset asserted during ENTRY
    do_reset();
    write_mask(4'b0000);
    irq = 4'b0001;
    tick();
    irq = '0; instr_done = 1'b1; pc_cur = 10'h0AA;
    tick();
    instr_done = 1'b0; pc_cur = '0;
    settle();
    chk("t6_in_entry", 32'(dbg_state), 32'(ST_ENTRY));
    reset = 1'b0;
    #1;
    chk("t6_rst_push", 32'(stk_push), 32'd0);
    chk("t6_rst_stall", 32'(cpu_stall), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_rst_count", 32'(stk_count), 32'd0);
    chk("t6_rst_pc_vec", 32'(pc_vec), 32'h3F0);
    tick();
    reset = 1'b1;
    tick();
    irq = 4'b0001;
    tick();
    irq = '0; instr_done = 1'b1;
    settle();
    chk("t6_mask_ones", 32'(cpu_stall), 32'd0);
    tick();
    instr_done = 1'b0;
    settle();
    chk("t6_post_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
